// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: rotates a one-hot column drive and debounces single-key presses and releases.
// Multi-row closures are rejected, and the scanner can optionally auto-repeat a held key.
module keypad_scanner #(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCAN_CYCLES     = 1000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000,
    localparam int KW = (NROWS * NCOLS > 2) ? $clog2(NROWS * NCOLS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NROWS-1:0] row,
    output logic [NCOLS-1:0] col,
    output logic [KW-1:0]    key_code,
    output logic             key_valid,
    output logic             key_held,
    output logic             multi_key
);
    localparam int RIW     = $clog2(NROWS);
    localparam int CIW     = $clog2(NCOLS);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES : SCAN_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REPW    = $clog2(REP_MAX + 2);

    localparam logic [CNTW-1:0] DB_LAST   = CNTW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTW-1:0] SC_LAST   = CNTW'(SCAN_CYCLES - 1);
    localparam logic [REPW-1:0] REP_FIRST = REPW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [REPW-1:0] REP_NEXT  = REPW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
    localparam logic [CIW-1:0]  CI_LAST   = CIW'(NCOLS - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

    state_t           r_state;
    logic [NROWS-1:0] r_sync1;
    logic [NROWS-1:0] r_rs;
    logic [NROWS-1:0] r_cr;
    logic [RIW-1:0]   r_ri;
    logic [CIW-1:0]   r_ci;
    logic [NCOLS-1:0] r_col;
    logic [CNTW-1:0]  r_cnt;
    logic [REPW-1:0]  r_rep;
    logic [KW-1:0]    r_key_code;
    logic             r_key_valid;
    logic             r_key_held;
    logic             r_multi_key;

    logic             w_any;
    logic             w_onehot;
    logic [RIW-1:0]   w_ri;
    logic [CIW-1:0]   w_ci_next;
    logic [NCOLS-1:0] w_col_next;
    logic [KW-1:0]    w_code;

    assign w_any      = |r_rs;
    assign w_onehot   = $onehot(r_rs);
    assign w_ci_next  = (r_ci == CI_LAST) ? '0 : r_ci + 1'b1;
    assign w_col_next = {r_col[NCOLS-2:0], r_col[NCOLS-1]};
    assign w_code     = KW'(int'(r_ri) * NCOLS + int'(r_ci));

    always_comb begin
        w_ri = '0;
        for (int i = 0; i < NROWS; i++) begin
            if (r_rs[i]) w_ri = RIW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SCAN;
            r_sync1     <= '0;
            r_rs        <= '0;
            r_cr        <= '0;
            r_ri        <= '0;
            r_ci        <= '0;
            r_col       <= NCOLS'(1);
            r_cnt       <= '0;
            r_rep       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_multi_key <= 1'b0;
        end else begin
            r_sync1     <= row;
            r_rs        <= r_sync1;
            r_key_valid <= 1'b0;
            r_multi_key <= 1'b0;
            case (r_state)
                SCAN: begin
                    // Rows are judged only once the synchronizer reflects this column.
                    if (r_cnt == SC_LAST) begin
                        r_cnt <= '0;
                        if (w_onehot) begin
                            r_ri    <= w_ri;
                            r_cr    <= r_rs;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_ci        <= w_ci_next;
                            r_col       <= w_col_next;
                            r_multi_key <= w_any;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (r_rs == r_cr) begin
                        if (r_cnt == DB_LAST) begin
                            r_state     <= HOLD;
                            r_key_valid <= 1'b1;
                            r_key_code  <= w_code;
                            r_key_held  <= 1'b1;
                            r_rep       <= REP_FIRST;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                        r_ci    <= w_ci_next;
                        r_col   <= w_col_next;
                    end
                end
                HOLD: begin
                    if (r_rs == r_cr) begin
                        if (REPEAT_EN != 0) begin
                            if (r_rep == '0) begin
                                r_key_valid <= 1'b1;
                                r_rep       <= REP_NEXT;
                            end else begin
                                r_rep <= r_rep - 1'b1;
                            end
                        end
                    end else begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                    end
                end
                RELEASE: begin
                    // A second key seen here only restarts the release count; it is never reported.
                    if (!w_any) begin
                        if (r_cnt == DB_LAST) begin
                            r_state    <= SCAN;
                            r_cnt      <= '0;
                            r_ci       <= w_ci_next;
                            r_col      <= w_col_next;
                            r_key_held <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_rs == r_cr) begin
                        r_state <= HOLD;
                        r_rep   <= REP_FIRST;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign multi_key = r_multi_key;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: two instances, without and with auto-repeat, fed by a modelled key matrix.
// Key events are checked against a scoreboard of expected code and cycle.
`timescale 1ns/1ps
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed_a = '0;
    logic [15:0] pressed_r = '0;
    logic [3:0]  row_a, row_r, col_a, col_r, code_a, code_r;
    logic        valid_a, held_a, multi_a, valid_r, held_r, multi_r;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          k0 = 0;

    typedef struct {int code; int at;} exp_t;
    exp_t q_a[$];
    exp_t q_r[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        row_a = '0;
        row_r = '0;
        for (int r = 0; r < 4; r++) begin
            row_a[r] = |(pressed_a[r*4 +: 4] & col_a);
            row_r[r] = |(pressed_r[r*4 +: 4] & col_r);
        end
    end

    keypad_scanner #(.NROWS(4), .NCOLS(4), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3),
                     .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_RATE(5)) dut (
        .clk(clk), .reset(reset), .row(row_a), .col(col_a), .key_code(code_a),
        .key_valid(valid_a), .key_held(held_a), .multi_key(multi_a));

    keypad_scanner #(.NROWS(4), .NCOLS(4), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3),
                     .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(5)) dut_rep (
        .clk(clk), .reset(reset), .row(row_r), .col(col_r), .key_code(code_r),
        .key_valid(valid_r), .key_held(held_r), .multi_key(multi_r));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - k0);
        end
    endtask

    task automatic monitor(input bit sel);
        int    last = 0;
        int    code;
        logic  v;
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            v    = sel ? valid_r : valid_a;
            code = sel ? int'(code_r) : int'(code_a);
            nm   = sel ? "rep" : "main";
            if (v) begin
                checks++;
                $display("[%s] key_valid code=%0d at cycle %0d", nm, code, cyc - k0);
                if ((sel ? q_r.size() : q_a.size()) == 0) begin
                    errors++;
                    $display("FAIL %s unexpected key_valid: got code=%0d cycle=%0d, expected none",
                             nm, code, cyc - k0);
                end else begin
                    e = sel ? q_r.pop_front() : q_a.pop_front();
                    if (code != e.code || cyc != e.at)
                    begin
                        errors++;
                        $display("FAIL %s key event: got code=%0d cycle=%0d, expected code=%0d cycle=%0d",
                                 nm, code, cyc - k0, e.code, e.at - k0);
                    end
                end
            end else if (!reset && code != last) begin
                checks++;
                errors++;
                $display("FAIL %s key_code changed without key_valid: got %0d, expected %0d",
                         nm, code, last);
            end
            last = code;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        pressed_a = '0;
        pressed_r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset col", int'(col_a), 1);
        chk("reset flags", int'({valid_a, held_a, multi_a}), 0);
        chk("reset key_code", int'(code_a), 0);
        reset = 1'b0;
        k0    = cyc;
    endtask

    task automatic check_scan(input int n);
        for (int k = 0; k < n; k++) begin
            chk("scan col", int'(col_a), 1 << ((k / 3) % 4));
            chk("scan flags", int'({valid_a, held_a, multi_a}), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        fork
            monitor(1'b0);
            monitor(1'b1);
        join_none

        // Idle scan rotation
        do_reset();
        check_scan(15);

        // Clean press r2c1, released after 30 cycles
        do_reset();
        pressed_a[2*4+1] = 1'b1;
        q_a.push_back('{9, k0 + 10});
        repeat (20) @(negedge clk);
        chk("col frozen", int'(col_a), 4'b0010);
        chk("held during key", int'(held_a), 1);
        repeat (10) @(negedge clk);
        pressed_a = '0;
        repeat (5) @(negedge clk);
        chk("held while releasing", int'(held_a), 1);
        repeat (7) @(negedge clk);
        chk("held after release", int'(held_a), 0);
        repeat (10) @(negedge clk);
        chk("queue main empty", q_a.size(), 0);

        // Bouncing r0c3 then stable
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pressed_a[3] = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        q_a.push_back('{3, k0 + 29});
        pressed_a[3] = 1'b1;
        repeat (30) @(negedge clk);
        chk("held after bounce", int'(held_a), 1);
        pressed_a = '0;
        repeat (20) @(negedge clk);
        chk("queue main empty", q_a.size(), 0);

        // Two keys in column 0: rejected every column-0 scan
        do_reset();
        pressed_a[1*4+0] = 1'b1;
        pressed_a[3*4+0] = 1'b1;
        for (int k = 0; k < 36; k++) begin
            chk("multi col", int'(col_a), 1 << ((k / 3) % 4));
            chk("multi_key", int'(multi_a), (k % 12 == 3) ? 1 : 0);
            chk("multi held", int'(held_a), 0);
            @(negedge clk);
        end
        pressed_a = '0;
        repeat (5) @(negedge clk);

        // Auto-repeat on r3c3
        do_reset();
        pressed_r[15] = 1'b1;
        q_r.push_back('{15, k0 + 16});
        q_r.push_back('{15, k0 + 26});
        q_r.push_back('{15, k0 + 31});
        q_r.push_back('{15, k0 + 36});
        q_r.push_back('{15, k0 + 41});
        repeat (42) @(negedge clk);
        pressed_r = '0;
        repeat (20) @(negedge clk);
        chk("queue rep empty", q_r.size(), 0);
        chk("rep held after release", int'(held_r), 0);

        // Reset while holding r1c2
        do_reset();
        pressed_a[1*4+2] = 1'b1;
        q_a.push_back('{6, k0 + 13});
        repeat (15) @(negedge clk);
        chk("held before reset", int'(held_a), 1);
        reset     = 1'b1;
        pressed_a = '0;
        @(negedge clk);
        chk("col after reset", int'(col_a), 1);
        chk("flags after reset", int'({valid_a, held_a, multi_a}), 0);
        reset = 1'b0;
        k0    = cyc;
        check_scan(8);
        chk("queue main empty", q_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter NROWS, default 4: number of row sense lines, legal 2..8.
REQ-002 SHALL have parameter NCOLS, default 4: number of column drive lines, legal 2..8.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed for press/release acceptance, legal >=2.
REQ-004 SHALL have parameter SCAN_CYCLES, default 1000: dwell cycles per column, legal >=3.
REQ-005 SHALL have parameter REPEAT_EN, default 0: 1 enables auto-repeat while a key is held.
REQ-006 SHALL have parameter REPEAT_DELAY, default 500000: cycles from the first key_valid to the first repeat.
REQ-007 SHALL have parameter REPEAT_RATE, default 100000: cycles between subsequent repeats.
REQ-008 clk  input  1  system clock, all state on rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 row  input  NROWS  asynchronous row sense, 1 = closed key on the driven column.
REQ-011 col  output  NCOLS  one-hot, active-high column drive.
REQ-012 key_code  output  KW=max(1,clog2(NROWS*NCOLS))  last accepted key, value = row_idx*NCOLS + col_idx.
REQ-013 key_valid  output  1  one-cycle pulse per accepted press or repeat.
REQ-014 key_held  output  1  high while a key is held or releasing.
REQ-015 multi_key  output  1  one-cycle pulse when a multi-row closure is rejected.

Function
REQ-016 row SHALL pass through a 2-flop synchronizer (rs); FSM uses only rs; row-to-rs latency 2 cycles.
REQ-017 FSM states SHALL be SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-018 SCAN: column index ci SHALL advance every SCAN_CYCLES cycles, wrapping NCOLS-1 -> 0; col SHALL be exactly one-hot in every cycle.
REQ-019 SCAN: rs SHALL be evaluated only on the last dwell cycle of a column; rs==0 -> advance.
REQ-020 SCAN: exactly one rs bit set -> capture ri and cr=rs, freeze col, enter DEBOUNCE with cnt=0.
REQ-021 SCAN: more than one rs bit set -> multi_key=1 for the next cycle only, no capture, ci advances normally.
REQ-022 DEBOUNCE: rs==cr increments cnt; rs!=cr -> SCAN at ci+1 (wrapping), no output pulses.
REQ-023 DEBOUNCE: cnt==DEBOUNCE_CYCLES-1 with rs==cr -> HOLD; key_valid SHALL be 1 in the first HOLD cycle, with key_code updated in that same cycle.
REQ-024 key_code SHALL change only in cycles where key_valid=1.
REQ-025 HOLD: rs==cr stays in HOLD; any other rs value (release or extra key) -> RELEASE with cnt=0.
REQ-026 REPEAT_EN=1: in HOLD, key_valid SHALL pulse REPEAT_DELAY cycles after the first pulse, then every REPEAT_RATE cycles, with unchanged key_code; the repeat timer restarts at REPEAT_DELAY on each HOLD entry.
REQ-027 REPEAT_EN=0: HOLD SHALL never pulse key_valid.
REQ-028 RELEASE: rs==0 for DEBOUNCE_CYCLES consecutive cycles -> SCAN at ci+1; rs==cr -> HOLD without key_valid; any other nonzero rs clears cnt and stays in RELEASE.
REQ-029 key_held SHALL be 1 exactly when state is HOLD or RELEASE.
REQ-030 A second key pressed while one is held SHALL never be reported until a full release completes.
REQ-031 Counters SHALL be sized for the largest parameter value, with no overflow or wrap.

Reset
REQ-032 While reset=1 at a clock edge: state=SCAN, ci=0, col=bit0, key_code=0, key_valid=0, key_held=0, multi_key=0, counters and synchronizer flops 0.
REQ-033 Reset in DEBOUNCE, HOLD or RELEASE SHALL abandon the key with no key_valid; after deassertion col[0] dwells SCAN_CYCLES cycles first.

Verification (NROWS=NCOLS=4, DEBOUNCE_CYCLES=4, SCAN_CYCLES=3; bench models matrix row[r]=|(pressed[r][c] & col[c]))
REQ-034 Reset 2 cycles, no keys -> col = 0001,0010,0100,1000,0001, 3 cycles each; all other outputs stay 0.
REQ-035 Key r2c1 held 30 cycles then released -> exactly one key_valid, key_code=9; key_held=1 until 4 clean cycles after release.
REQ-036 Key r0c3 toggled every 2 cycles for 12 cycles, then held -> no key_valid during bounce; one key_valid with key_code=3 after stability.
REQ-037 Keys r1c0 and r3c0 held together -> multi_key pulse each scan of column 0, never key_valid; col keeps rotating.
REQ-038 REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_RATE=5, key r3c3 held 28 cycles after the first pulse -> key_valid at +0, +10, +15, +20, +25, key_code=15 each time.
REQ-039 Reset asserted in HOLD -> next cycle col=0001, key_held=0, no key_valid; after release, normal scan resumes.
